memory_port_arbiter: RTL
========================

Name: memory_port_arbiter

Overview:
- Shares the single-ported main memory between the instruction-fetch requester (port 0) and the load/store requester (port 1).
- Each request is latched and presented to memory. The arbiter holds it until the memory acknowledges, then returns read data to the owning requester with a one-cycle done pulse.
- Sits between the multi-cycle pipeline (fetch_Request/fetch_Receive and execute/memRead stages) and the memory model.
- A timeout counter stops a hung memory from stalling the pipeline forever.

Parameters:
- ADDR_WIDTH, 32, width of the address buses
- DATA_WIDTH, 32, width of the data buses
- TIMEOUT, 255, maximum cycles to wait for mem_ready before aborting; 0 disables the timeout

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- req0  input  1  fetch request; held high until done0
- addr0  input  ADDR_WIDTH  fetch address
- done0  output  1  one-cycle pulse: fetch transaction finished
- rdata0  output  DATA_WIDTH  fetch read data; valid while done0 is high
- req1  input  1  load/store request; held high until done1
- addr1  input  ADDR_WIDTH  load/store address
- we1  input  1  1 = store, 0 = load
- wdata1  input  DATA_WIDTH  store data
- byteEn1  input  DATA_WIDTH/8  store byte enables
- done1  output  1  one-cycle pulse: load/store transaction finished
- rdata1  output  DATA_WIDTH  load data; valid while done1 is high
- err  output  1  high together with doneN when the transaction timed out
- mem_en  output  1  memory access strobe
- mem_addr  output  ADDR_WIDTH  memory address
- mem_we  output  1  memory write enable
- mem_wdata  output  DATA_WIDTH  memory write data
- mem_byteEn  output  DATA_WIDTH/8  memory byte enables
- mem_ready  input  1  memory completion; mem_rdata valid in the same cycle
- mem_rdata  input  DATA_WIDTH  memory read data

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE; every output = 0.
  - lastGrant = 1, so port 0 wins the first tie.
  - Timeout counter = 0.
  - Reset asserted mid-transaction aborts it immediately: mem_en drops, no done pulse is produced.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - Only one of req0/req1 high: grant it.
  - Both high: grant the port != lastGrant (round-robin).
  - On grant: latch owner, address, we, wdata and byteEn (byteEn forced all-ones and we = 0 for port 0); load lastGrant; go to ACCESS.
- ACCESS:
  - mem_en = 1; mem_* are driven from the latched registers and held stable, whatever the requester inputs do.
  - Each cycle with mem_ready = 0 increments the counter.
  - mem_ready = 1: capture mem_rdata into the owner's rdata register, go to DONE.
  - TIMEOUT != 0 and counter == TIMEOUT with mem_ready = 0: set the error flag, leave rdata = 0, go to DONE.
  - mem_ready wins if it arrives in the same cycle as expiry.
- DONE:
  - mem_en = 0; owner's doneN = 1 for exactly one cycle; err = error flag.
  - Stores also return done; rdata is don't-care but driven 0.
  - Next cycle: clear the counter and error flag, return to IDLE.
- Latency:
  - Request seen at edge N gives mem_en high from cycle N+1.
  - mem_ready at edge M gives done at cycle M+1.
  - Minimum request-to-done is 3 cycles; back-to-back grants are separated by at least one IDLE cycle.
- rdata0/rdata1 are registered and hold their last value until the next completion on that port.
- A requester that drops its req during ACCESS does not cancel the access; its done still pulses.
- doneN is never asserted for the port that does not own the transaction.
- mem_ready outside ACCESS is ignored.

Test Plan:
- Fetch only: req0 = 1, addr0 = 0x100; memory returns 0xDEADBEEF after 2 wait cycles -> mem_en high for 3 cycles with mem_addr = 0x100, mem_we = 0, mem_byteEn = 0xF; done0 pulses one cycle with rdata0 = 0xDEADBEEF, err = 0.
- Store: req1 = 1, we1 = 1, addr1 = 0x20, wdata1 = 0x12345678, byteEn1 = 0x3, zero wait -> mem_* match the inputs; done1 pulses at request+3 cycles; done0 stays 0.
- Contention: req0 and req1 both high from reset -> port 0 granted first, then port 1, then port 0 again; one IDLE gap between grants.
- Timeout: TIMEOUT = 4, mem_ready held 0 -> mem_en high for 5 cycles, then done pulses with err = 1 and rdata = 0. Repeat with mem_ready arriving on the expiry cycle -> err = 0 and the data is captured.
- Input churn: change addr1/wdata1 and drop req1 during ACCESS -> mem_addr and mem_wdata unchanged; done1 still pulses.
- Reset mid-ACCESS: assert reset while mem_en = 1 -> all outputs 0 immediately and no done pulse. After release, the pending req0 is re-granted normally.

Source files
------------

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: shares one single-ported memory between the fetch
// port (0) and the load/store port (1), using round-robin on ties.
// Ports: clk, reset (async, active-low)
//   port 0  req0/addr0 -> done0/rdata0 (fetch, read only)
//   port 1  req1/addr1/we1/wdata1/byteEn1 -> done1/rdata1 (load/store)
//   err     timeout flag, valid with doneN
//   mem_*   memory strobe/address/write side, mem_ready/mem_rdata back
module memory_port_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req0,
    input  logic [ADDR_WIDTH-1:0]   addr0,
    output logic                    done0,
    output logic [DATA_WIDTH-1:0]   rdata0,
    input  logic                    req1,
    input  logic [ADDR_WIDTH-1:0]   addr1,
    input  logic                    we1,
    input  logic [DATA_WIDTH-1:0]   wdata1,
    input  logic [DATA_WIDTH/8-1:0] byteEn1,
    output logic                    done1,
    output logic [DATA_WIDTH-1:0]   rdata1,
    output logic                    err,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_byteEn,
    input  logic                    mem_ready,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    owner_q;
    logic                    last_grant_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    we_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [BW-1:0]           be_q;
    logic [CW-1:0]           cnt_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   rdata0_q;
    logic [DATA_WIDTH-1:0]   rdata1_q;
    logic                    any_req;
    logic                    grant;
    logic                    expire;

    assign any_req = req0 | req1;

    // On a tie the port that did not win last time is served.
    always_comb begin
        grant = 1'b0;
        unique case ({req1, req0})
            2'b11:   grant = ~last_grant_q;
            2'b10:   grant = 1'b1;
            default: grant = 1'b0;
        endcase
    end

    // A ready arriving on the expiry cycle takes precedence.
    assign expire = (TIMEOUT != 0) && (cnt_q == TO_VAL) && !mem_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (any_req) state_d = ACCESS;
            ACCESS:  if (mem_ready || expire) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latched request, timeout counter and per-port read data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            be_q         <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        owner_q      <= grant;
                        last_grant_q <= grant;
                        if (grant) begin
                            addr_q  <= addr1;
                            we_q    <= we1;
                            wdata_q <= wdata1;
                            be_q    <= byteEn1;
                        end else begin
                            addr_q  <= addr0;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                            be_q    <= '1;
                        end
                    end
                end
                ACCESS: begin
                    if (mem_ready) begin
                        // Stores complete with zero read data.
                        if (owner_q) begin
                            rdata1_q <= we_q ? '0 : mem_rdata;
                        end else begin
                            rdata0_q <= mem_rdata;
                        end
                    end else if (expire) begin
                        err_q <= 1'b1;
                        if (owner_q) begin
                            rdata1_q <= '0;
                        end else begin
                            rdata0_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
                default: begin
                    cnt_q <= '0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        mem_en     = 1'b0;
        mem_addr   = '0;
        mem_we     = 1'b0;
        mem_wdata  = '0;
        mem_byteEn = '0;
        done0      = 1'b0;
        done1      = 1'b0;
        err        = 1'b0;
        unique case (state_q)
            ACCESS: begin
                mem_en     = 1'b1;
                mem_addr   = addr_q;
                mem_we     = we_q;
                mem_wdata  = wdata_q;
                mem_byteEn = be_q;
            end
            DONE: begin
                done0 = ~owner_q;
                done1 = owner_q;
                err   = err_q;
            end
            default: begin
                mem_en = 1'b0;
            end
        endcase
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;

endmodule
